// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle 16-bit core.
// master: controller side (drives strobes); slave: datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             mem_ready;
  logic [3:0]       opcode;
  logic             zero;
  logic [2:0]       state;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             mem_read;
  logic             mem_write;
  logic             addr_sel;
  logic             alu_src_imm;
  logic             sext_en;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             wb_sel;
  logic             illegal_op;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, mem_ready, opcode, zero,
    output state, ir_write, pc_write, pc_src,
    output mem_read, mem_write, addr_sel,
    output alu_src_imm, sext_en, alu_op,
    output reg_write, wb_sel, illegal_op,
    output halted, instr_count
  );

  modport slave (
    output run, mem_ready, opcode, zero,
    input  state, ir_write, pc_write, pc_src,
    input  mem_read, mem_write, addr_sel,
    input  alu_src_imm, sext_en, alu_op,
    input  reg_write, wb_sel, illegal_op,
    input  halted, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
// Ports: clk, rst_n (sync, active low), bus (multicycle_ctrl_if.master).
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  logic       ir_write, pc_write;
  logic [1:0] pc_src;
  logic       mem_read, mem_write, addr_sel;
  logic       alu_src_imm, sext_en;
  logic [1:0] alu_op;
  logic       reg_write, wb_sel;
  logic       illegal_op, halted;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    retire      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 1'b0;
    alu_src_imm = 1'b0;
    sext_en     = 1'b0;
    alu_op      = 2'd0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.run) begin
          mem_read = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        op_d = bus.opcode;
        unique case (1'b1)
          bus.opcode == OP_HALT: state_d = S_HALT;
          bus.opcode == OP_JMP: begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_d  = S_FETCH;
            retire   = 1'b1;
          end
          bus.opcode <= OP_BEQ: state_d = S_EXEC;
          default: begin
            // Undefined opcodes retire as a NOP.
            illegal_op = 1'b1;
            state_d    = S_FETCH;
            retire     = 1'b1;
          end
        endcase
      end

      S_EXEC: begin
        unique case (1'b1)
          op_q == OP_BEQ: begin
            alu_op  = 2'd1;
            sext_en = 1'b1;
            // PC already holds PC+1, so offset is from next instr.
            if (bus.zero) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          op_q == OP_ADDI: begin
            alu_src_imm = 1'b1;
            sext_en     = 1'b1;
            state_d     = S_WB;
          end
          op_q == OP_LW,
          op_q == OP_SW: begin
            alu_src_imm = 1'b1;
            sext_en     = 1'b1;
            state_d     = S_MEM;
          end
          default: begin
            // R-type: opcode low bits equal the ALU op encoding.
            alu_op  = op_q[1:0];
            state_d = S_WB;
          end
        endcase
      end

      S_MEM: begin
        addr_sel  = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q != OP_LW);
        if (bus.mem_ready) begin
          if (op_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (op_q == OP_LW);
        state_d   = S_FETCH;
        retire    = 1'b1;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase

    cnt_d = cnt_q;
    if (retire && !(&cnt_q)) cnt_d = cnt_q + 1'b1;

    // Keep the datapath quiet for the whole reset assertion.
    if (!rst_n) begin
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = 1'b0;
      alu_src_imm = 1'b0;
      sext_en     = 1'b0;
      alu_op      = 2'd0;
      reg_write   = 1'b0;
      wb_sel      = 1'b0;
      illegal_op  = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.addr_sel    = addr_sel;
  assign bus.alu_src_imm = alu_src_imm;
  assign bus.sext_en     = sext_en;
  assign bus.alu_op      = alu_op;
  assign bus.reg_write   = reg_write;
  assign bus.wb_sel      = wb_sel;
  assign bus.illegal_op  = illegal_op;
  assign bus.halted      = halted;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl.
// A second instance with a 3-bit counter exercises saturation.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] op = 4'd0;
  logic       z = 1'b0;

  multicycle_ctrl_if #(.CNT_W(16)) bus ();
  multicycle_ctrl_if #(.CNT_W(3))  bus2 ();

  assign bus.run        = run;
  assign bus.mem_ready  = rdy;
  assign bus.opcode     = op;
  assign bus.zero       = z;
  assign bus2.run       = run;
  assign bus2.mem_ready = rdy;
  assign bus2.opcode    = op;
  assign bus2.zero      = z;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  multicycle_ctrl #(.CNT_W(3)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  // Strobe vector bit positions.
  localparam logic [14:0] IRW = 15'h4000;
  localparam logic [14:0] PCW = 15'h2000;
  localparam logic [14:0] PS1 = 15'h0800;
  localparam logic [14:0] PS2 = 15'h1000;
  localparam logic [14:0] MRD = 15'h0400;
  localparam logic [14:0] MWR = 15'h0200;
  localparam logic [14:0] ADS = 15'h0100;
  localparam logic [14:0] IMM = 15'h0080;
  localparam logic [14:0] SXT = 15'h0040;
  localparam logic [14:0] SUB = 15'h0010;
  localparam logic [14:0] AND = 15'h0020;
  localparam logic [14:0] ORR = 15'h0030;
  localparam logic [14:0] RGW = 15'h0008;
  localparam logic [14:0] WBS = 15'h0004;
  localparam logic [14:0] ILL = 15'h0002;
  localparam logic [14:0] HLT = 15'h0001;
  localparam logic [14:0] FET = IRW | PCW | MRD;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        rdy;
    logic [3:0]  op;
    logic        z;
    logic [2:0]  st;
    logic [14:0] sig;
    int          cnt;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic r, logic ru, logic rd,
                              logic [3:0] o, logic zz,
                              logic [2:0] s, logic [14:0] g,
                              int c);
    vec_t v;
    v.rst_n = r; v.run = ru; v.rdy = rd;
    v.op = o; v.z = zz; v.st = s; v.sig = g; v.cnt = c;
    return v;
  endfunction

  function automatic logic [14:0] sig_of1();
    return {bus.ir_write, bus.pc_write, bus.pc_src,
            bus.mem_read, bus.mem_write, bus.addr_sel,
            bus.alu_src_imm, bus.sext_en, bus.alu_op,
            bus.reg_write, bus.wb_sel, bus.illegal_op,
            bus.halted};
  endfunction

  task automatic step(input vec_t v, input string nm);
    int c2;
    @(negedge clk);
    rst_n = v.rst_n; run = v.run; rdy = v.rdy;
    op = v.op; z = v.z;
    #1;
    c2 = (v.cnt > 7) ? 7 : v.cnt;
    n_cmp++;
    if (bus.state !== v.st) begin
      n_bad++;
      $display("FAIL %s state: got %0d want %0d", nm, bus.state, v.st);
    end
    n_cmp++;
    if (sig_of1() !== v.sig) begin
      n_bad++;
      $display("FAIL %s strobes: got %h want %h", nm, sig_of1(), v.sig);
    end
    n_cmp++;
    if (bus.instr_count !== 16'(v.cnt)) begin
      n_bad++;
      $display("FAIL %s count: got %0d want %0d", nm,
               bus.instr_count, v.cnt);
    end
    n_cmp++;
    if (bus2.instr_count !== 3'(c2)) begin
      n_bad++;
      $display("FAIL %s satcount: got %0d want %0d", nm,
               bus2.instr_count, c2);
    end
  endtask

  // Fetch helper rows (zero-wait).
  function automatic vec_t f(int c);
    return mk(1, 1, 1, 4'd0, 0, 3'd0, FET, c);
  endfunction

  initial begin
    // reset held 2 cycles with run/ready high
    tbl.push_back(mk(0, 1, 1, 4'd0, 0, 3'd0, 15'd0, 0));
    // ADD
    tbl.push_back(f(0));
    tbl.push_back(mk(1, 1, 1, 4'd0, 0, 3'd1, 15'd0, 0));
    tbl.push_back(mk(1, 1, 1, 4'd0, 0, 3'd2, 15'd0, 0));
    tbl.push_back(mk(1, 1, 1, 4'd0, 0, 3'd4, RGW, 0));
    // ADDI
    tbl.push_back(f(1));
    tbl.push_back(mk(1, 1, 1, 4'd4, 0, 3'd1, 15'd0, 1));
    tbl.push_back(mk(1, 1, 1, 4'd4, 0, 3'd2, IMM | SXT, 1));
    tbl.push_back(mk(1, 1, 1, 4'd4, 0, 3'd4, RGW, 1));
    // SUB
    tbl.push_back(f(2));
    tbl.push_back(mk(1, 1, 1, 4'd1, 0, 3'd1, 15'd0, 2));
    tbl.push_back(mk(1, 1, 1, 4'd1, 0, 3'd2, SUB, 2));
    tbl.push_back(mk(1, 1, 1, 4'd1, 0, 3'd4, RGW, 2));
    // OR
    tbl.push_back(f(3));
    tbl.push_back(mk(1, 1, 1, 4'd3, 0, 3'd1, 15'd0, 3));
    tbl.push_back(mk(1, 1, 1, 4'd3, 0, 3'd2, ORR, 3));
    tbl.push_back(mk(1, 1, 1, 4'd3, 0, 3'd4, RGW, 3));
    // AND
    tbl.push_back(f(4));
    tbl.push_back(mk(1, 1, 1, 4'd2, 0, 3'd1, 15'd0, 4));
    tbl.push_back(mk(1, 1, 1, 4'd2, 0, 3'd2, AND, 4));
    tbl.push_back(mk(1, 1, 1, 4'd2, 0, 3'd4, RGW, 4));
    // LW, 3 wait cycles in FETCH and MEM
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 0, 4'd5, 0, 3'd0, MRD, 5));
    tbl.push_back(f(5));
    tbl.push_back(mk(1, 1, 0, 4'd5, 0, 3'd1, 15'd0, 5));
    tbl.push_back(mk(1, 1, 0, 4'd5, 0, 3'd2, IMM | SXT, 5));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 1, 0, 4'd5, 0, 3'd3, MRD | ADS, 5));
    tbl.push_back(mk(1, 1, 1, 4'd5, 0, 3'd3, MRD | ADS, 5));
    tbl.push_back(mk(1, 1, 0, 4'd5, 0, 3'd4, RGW | WBS, 5));
    // SW, one wait in MEM
    tbl.push_back(f(6));
    tbl.push_back(mk(1, 1, 1, 4'd6, 0, 3'd1, 15'd0, 6));
    tbl.push_back(mk(1, 1, 1, 4'd6, 0, 3'd2, IMM | SXT, 6));
    tbl.push_back(mk(1, 1, 0, 4'd6, 0, 3'd3, MWR | ADS, 6));
    tbl.push_back(mk(1, 1, 1, 4'd6, 0, 3'd3, MWR | ADS, 6));
    // BEQ taken / not taken
    tbl.push_back(f(7));
    tbl.push_back(mk(1, 1, 1, 4'd7, 1, 3'd1, 15'd0, 7));
    tbl.push_back(mk(1, 1, 1, 4'd7, 1, 3'd2,
                     PCW | PS1 | SUB | SXT, 7));
    tbl.push_back(f(8));
    tbl.push_back(mk(1, 1, 1, 4'd7, 0, 3'd1, 15'd0, 8));
    tbl.push_back(mk(1, 1, 1, 4'd7, 0, 3'd2, SUB | SXT, 8));
    // illegal 1011 then JMP
    tbl.push_back(f(9));
    tbl.push_back(mk(1, 1, 1, 4'hB, 0, 3'd1, ILL, 9));
    tbl.push_back(f(10));
    tbl.push_back(mk(1, 1, 1, 4'd8, 0, 3'd1, PCW | PS2, 10));
    // run low blocks fetch; drop mid-instruction does not stall
    tbl.push_back(mk(1, 0, 1, 4'd0, 0, 3'd0, 15'd0, 11));
    tbl.push_back(mk(1, 0, 1, 4'd0, 0, 3'd0, 15'd0, 11));
    tbl.push_back(f(11));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 3'd1, 15'd0, 11));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 3'd2, 15'd0, 11));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 3'd4, RGW, 11));
    tbl.push_back(mk(1, 0, 1, 4'd0, 0, 3'd0, 15'd0, 12));

    // unchecked first reset cycle: state is unknown before any edge
    @(negedge clk);
    rst_n = 0; run = 1; rdy = 1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // HALT, then 20 cycles of toggling inputs
    step(f(12), "halt_fetch");
    step(mk(1, 1, 1, 4'hF, 0, 3'd1, 15'd0, 12), "halt_dec");
    for (int i = 0; i < 20; i++)
      step(mk(1, i[0], i[1], 4'd5, i[2], 3'd5, HLT, 12),
           $sformatf("halt%0d", i));
    step(mk(0, 1, 1, 4'd0, 0, 3'd5, 15'd0, 12), "halt_rst");
    step(mk(1, 0, 1, 4'd0, 0, 3'd0, 15'd0, 0), "halt_out");

    // reset during LW memory wait
    step(f(0), "lwr_fetch");
    step(mk(1, 1, 1, 4'd5, 0, 3'd1, 15'd0, 0), "lwr_dec");
    step(mk(1, 1, 1, 4'd5, 0, 3'd2, IMM | SXT, 0), "lwr_exec");
    step(mk(1, 1, 0, 4'd5, 0, 3'd3, MRD | ADS, 0), "lwr_wait");
    step(mk(0, 1, 0, 4'd5, 0, 3'd3, 15'd0, 0), "lwr_rst");
    step(mk(1, 0, 1, 4'd5, 0, 3'd0, 15'd0, 0), "lwr_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
